// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Each transaction runs IDLE -> ISSUE -> RESP -> DONE, and every output is registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic              lat_we;

  logic              win_c;
  logic              win_we_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;

  // Winner selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    win_c = 1'b0;
    if (req0 && req1) begin
      win_c = ~last_grant;
    end else if (req1) begin
      win_c = 1'b1;
    end
    win_we_c    = win_c ? we1 : we0;
    win_addr_c  = win_c ? addr1 : addr0;
    win_wdata_c = win_c ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= ISSUE;
            owner      <= win_c;
            last_grant <= win_c;
            lat_we     <= win_we_c;
            mem_addr   <= win_addr_c;
            mem_wdata  <= win_wdata_c;
            mem_write  <= win_we_c;
            mem_read   <= ~win_we_c;
            gnt0       <= ~win_c;
            gnt1       <= win_c;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          state <= RESP;
        end
        RESP: begin
          // Memory data is valid this cycle for a read; only the owner's rdata moves.
          if (!lat_we) begin
            if (owner) begin
              rdata1 <= mem_rdata;
            end else begin
              rdata0 <= mem_rdata;
            end
          end
          ack0  <= ~owner;
          ack1  <= owner;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and random traffic
// checked against a transaction-level model of memory contents and grant order.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_write, mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Attached memory: write and read data both registered on the strobe edge.
  logic [DATA_W-1:0] mem_arr [32];
  initial for (int i = 0; i < 32; i++) mem_arr[i] = '0;
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem_arr[mem_addr];
  end

  logic [1:0] gnt_v, ack_v;
  assign gnt_v = {gnt1, gnt0};
  assign ack_v = {ack1, ack0};

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: memory contents, expected rdata per requester, grant history.
  logic [DATA_W-1:0] ref_mem [32];
  logic [DATA_W-1:0] exp_rdata [2];
  int                grant_hist[$];

  bit                t_req [2];
  bit                t_we [2];
  logic [ADDR_W-1:0] t_addr [2];
  logic [DATA_W-1:0] t_wdata [2];
  int                last_first;
  logic [DATA_W-1:0] last_rdata;

  // Protocol monitor, sampled on the falling edge.
  bit mon_en = 1'b0;
  bit mon_out [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_excl", 32'(mem_write && mem_read), 32'd0);
      check("gnt_excl", 32'(gnt0 && gnt1), 32'd0);
      check("ack_excl", 32'(ack0 && ack1), 32'd0);
      check("strobe_with_gnt", 32'(mem_write || mem_read), 32'(gnt0 || gnt1));
      if (rst) begin
        mon_out = '{1'b0, 1'b0};
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (ack_v[n]) begin
            check("ack_has_gnt", 32'(mon_out[n]), 32'd1);
            mon_out[n] = 1'b0;
          end
          if (gnt_v[n]) begin
            check("gnt_not_outstanding", 32'(mon_out[n]), 32'd0);
            mon_out[n] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the t_* requests at once from IDLE and follows them to completion.
  task automatic run_txns();
    bit pend [2];
    bit outs [2];
    int gcyc [2];
    int ngr;
    int expn;
    bit done;
    pend = t_req;
    outs = '{1'b0, 1'b0};
    gcyc = '{0, 0};
    ngr = 0;
    done = 1'b0;
    last_first = -1;
    last_rdata = '0;
    req0 = t_req[0]; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wdata[0];
    req1 = t_req[1]; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wdata[1];
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (gnt_v[n]) begin
          check("gnt_expected", 32'(pend[n]), 32'd1);
          if (pend[0] && pend[1])
            expn = (grant_hist.size() == 0) ? 0 : 1 - grant_hist[$];
          else
            expn = pend[0] ? 0 : 1;
          check("gnt_order", 32'(n), 32'(expn));
          check("gnt_latency", 32'(cyc), (ngr == 0) ? 32'd0 : 32'd4);
          check("issue_write", 32'(mem_write), 32'(t_we[n]));
          check("issue_read", 32'(mem_read), 32'(!t_we[n]));
          check("issue_addr", 32'(mem_addr), 32'(t_addr[n]));
          if (t_we[n]) check("issue_wdata", 32'(mem_wdata), 32'(t_wdata[n]));
          check("busy_issue", 32'(busy), 32'd1);
          grant_hist.push_back(n);
          if (last_first < 0) last_first = n;
          pend[n] = 1'b0;
          outs[n] = 1'b1;
          gcyc[n] = cyc;
          ngr++;
          if (n == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        if (ack_v[n]) begin
          check("ack_expected", 32'(outs[n]), 32'd1);
          check("ack_latency", 32'(cyc - gcyc[n]), 32'd2);
          check("busy_done", 32'(busy), 32'd1);
          if (t_we[n]) ref_mem[t_addr[n]] = t_wdata[n];
          else exp_rdata[n] = ref_mem[t_addr[n]];
          check("rdata0", 32'(rdata0), 32'(exp_rdata[0]));
          check("rdata1", 32'(rdata1), 32'(exp_rdata[1]));
          last_rdata = (n == 0) ? rdata0 : rdata1;
          outs[n] = 1'b0;
        end
      end
      done = !pend[0] && !pend[1] && !outs[0] && !outs[1];
    end
    check("txn_done", 32'(done), 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic set_txn(input int n, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    t_req[n] = 1'b1; t_we[n] = we; t_addr[n] = a; t_wdata[n] = d;
  endtask

  task automatic clear_txn();
    t_req = '{1'b0, 1'b0};
    t_we = '{1'b0, 1'b0};
    t_addr = '{'0, '0};
    t_wdata = '{'0, '0};
  endtask

  typedef struct {
    int                n;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[$];
    int gcy[$];
    bit bad;

    vecs[0] = '{0, 1'b1, 5'd5,  8'hA5, 8'h00};
    vecs[1] = '{0, 1'b0, 5'd5,  8'h00, 8'hA5};
    vecs[2] = '{1, 1'b1, 5'd31, 8'h3C, 8'h00};
    vecs[3] = '{1, 1'b0, 5'd31, 8'h00, 8'h3C};
    vecs[4] = '{0, 1'b1, 5'd0,  8'h11, 8'h00};
    vecs[5] = '{1, 1'b0, 5'd0,  8'h00, 8'h11};
    vecs[6] = '{1, 1'b1, 5'd0,  8'hFF, 8'h00};
    vecs[7] = '{0, 1'b0, 5'd0,  8'h00, 8'hFF};

    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    exp_rdata = '{'0, '0};
    clear_txn();

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check("rst_ack", 32'({ack1, ack0}), 32'd0);
    check("rst_strobes", 32'({mem_write, mem_read}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // First tie after reset goes to requester 0
    clear_txn();
    set_txn(0, 1'b1, 5'd0, 8'h5A);
    set_txn(1, 1'b0, 5'd0, 8'h00);
    run_txns();
    check("tie_first_after_reset", 32'(last_first), 32'd0);
    check("tie_read_sees_write", 32'(rdata1), 32'h5A);

    // Continuous dual requests alternate, one grant every 4 cycles
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (gnt_v[n]) begin
          gseq.push_back(n);
          gcy.push_back(cyc);
          grant_hist.push_back(n);
        end
      end
      if (gseq.size() >= 4) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    check("cont_count", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gseq.size()) begin
        check("cont_order", 32'(gseq[i]), 32'(i % 2));
        check("cont_spacing", 32'(gcy[i]), 32'(4 * i));
      end
    end
    exp_rdata[0] = ref_mem[0];
    exp_rdata[1] = ref_mem[0];
    check("cont_rdata0", 32'(rdata0), 32'h5A);
    check("cont_rdata1", 32'(rdata1), 32'h5A);

    // Vector table of single-requester transactions
    for (int i = 0; i < 8; i++) begin
      clear_txn();
      set_txn(vecs[i].n, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      run_txns();
      if (!vecs[i].we) check("vec_rdata", 32'(last_rdata), 32'(vecs[i].exp_rdata));
    end

    // Isolation: requester 1 reads while requester 0 holds its value
    clear_txn(); set_txn(0, 1'b0, 5'd5, 8'h00); run_txns();
    check("iso_rdata0_a5", 32'(rdata0), 32'hA5);
    clear_txn(); set_txn(1, 1'b0, 5'd31, 8'h00); run_txns();
    check("iso_rdata1", 32'(rdata1), 32'h3C);
    check("iso_rdata0_kept", 32'(rdata0), 32'hA5);
    clear_txn(); set_txn(0, 1'b1, 5'd9, 8'h42); run_txns();
    check("write_keeps_rdata0", 32'(rdata0), 32'hA5);

    // Late drop: req1 pulsed while requester 0 is in RESP
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
    tick();
    check("late_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    grant_hist.push_back(0);
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3;
    tick();
    req1 = 1'b0;
    check("late_ack0", 32'(ack0), 32'd1);
    exp_rdata[0] = ref_mem[5];
    check("late_rdata0", 32'(rdata0), 32'(exp_rdata[0]));
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      bad |= gnt1 | ack1;
    end
    check("late_no_txn1", 32'(bad), 32'd0);

    // Reset while a write to addr 7 is in ISSUE
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 8'h77;
    tick();
    check("abort_gnt0", 32'(gnt0), 32'd1);
    check("abort_strobe", 32'(mem_write), 32'd1);
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    check("abort_write_low", 32'(mem_write), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack", 32'({ack1, ack0}), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
    check("abort_rdata", 32'({rdata1, rdata0}), 32'd0);
    rst = 1'b0;
    grant_hist.delete();
    exp_rdata = '{'0, '0};
    ref_mem[7] = 8'h77;  // strobe was on the bus for the whole ISSUE cycle
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      bad |= ack0 | ack1 | gnt0 | gnt1;
    end
    check("abort_no_ack", 32'(bad), 32'd0);
    clear_txn();
    set_txn(0, 1'b0, 5'd7, 8'h00);
    set_txn(1, 1'b0, 5'd31, 8'h00);
    run_txns();
    check("abort_next_tie", 32'(last_first), 32'd0);

    // Random traffic against the model
    for (int it = 0; it < 40; it++) begin
      clear_txn();
      for (int n = 0; n < 2; n++) begin
        logic [ADDR_W-1:0] a;
        case ($urandom_range(0, 3))
          0: a = '0;
          1: a = '1;
          default: a = ADDR_W'($urandom);
        endcase
        if ($urandom_range(0, 1) == 1)
          set_txn(n, 1'($urandom), a, DATA_W'($urandom));
      end
      if (!t_req[0] && !t_req[1]) set_txn(0, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      run_txns();
      repeat ($urandom_range(0, 2)) tick();
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 5, memory address width (32 locations).
REQ-002 Parameter: DATA_W, 8, memory data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 reqN  in  1  (N=0,1) requester N transaction request.
REQ-006 weN  in  1  (N=0,1) 1=write, 0=read; valid while reqN high.
REQ-007 addrN  in  ADDR_W  (N=0,1) transaction address.
REQ-008 wdataN  in  DATA_W  (N=0,1) write data.
REQ-009 gntN  out  1  (N=0,1) one-cycle pulse: command of requester N captured.
REQ-010 ackN  out  1  (N=0,1) one-cycle pulse: transaction of requester N complete.
REQ-011 rdataN  out  DATA_W  (N=0,1) read data; valid in the cycle ackN=1 for a read.
REQ-012 mem_write  out  1  memory write strobe.
REQ-013 mem_read  out  1  memory read strobe.
REQ-014 mem_addr  out  ADDR_W  memory address.
REQ-015 mem_wdata  out  DATA_W  memory write data.
REQ-016 mem_rdata  in  DATA_W  memory read data; registered by memory on the edge ending the mem_read cycle.
REQ-017 busy  out  1  high whenever state != IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, RESP, DONE; all outputs registered.
REQ-019 IDLE: req0/req1 sampled each edge; no request -> stay IDLE.
REQ-020 IDLE with any request: winner chosen, its we/addr/wdata latched, state -> ISSUE, gnt of winner = 1 for the ISSUE cycle only.
REQ-021 Arbitration: single requester wins; both requesting -> requester not granted last (round-robin via last_grant register).
REQ-022 last_grant updated only on grant; ties strictly alternate 0,1,0,1 under continuous dual requests.
REQ-023 ISSUE (exactly one cycle): mem_write=latched we, mem_read=!latched we; mem_addr/mem_wdata from latches; state -> RESP.
REQ-024 mem_write and mem_read never both high; both 0 in every state except ISSUE.
REQ-025 mem_addr/mem_wdata hold last latched values outside ISSUE.
REQ-026 RESP (one cycle): for a read, mem_rdata captured into rdata of the owner; state -> DONE.
REQ-027 DONE (one cycle): ack of owner = 1; state -> IDLE; rdata of non-owner unchanged.
REQ-028 Write ack also in DONE; rdata of owner unchanged for writes.
REQ-029 Latency: req sampled at edge E -> gnt cycle E+1, strobe cycle E+1, ack cycle E+3; next request sampled no earlier than the edge ending DONE; peak rate one transaction per 4 cycles.
REQ-030 Requests not sampled in ISSUE/RESP/DONE; requester deasserts reqN in its gnt cycle, otherwise a second transaction is issued.
REQ-031 reqN dropped before being sampled in IDLE -> no transaction, no gnt, no ack.
REQ-032 Full 0..2^ADDR_W-1 address range passed unmodified; no wrap or offset.

Reset
REQ-033 rst=1 at an edge: state IDLE, last_grant=1 (requester 0 wins first tie), all gnt/ack/mem_write/mem_read/busy=0, mem_addr/mem_wdata/rdata0/rdata1=0.
REQ-034 Reset mid-transaction: transaction aborted, no ack issued, strobe removed at that edge; reset dominates all inputs.

Verification
REQ-035 Write then read: req0 we0=1 addr0=5 wdata0=0xA5; then req0 we0=0 addr0=5 -> mem_write one cycle at addr 5, ack0 3 cycles after sample; read ack0 with rdata0=0xA5.
REQ-036 Simultaneous after reset: req0 and req1 both high -> gnt0 first, then gnt1 after ack0; continuous dual requests -> gnt order 0,1,0,1.
REQ-037 Isolation: req1 read addr 31 holding 0x3C while rdata0=0xA5 -> ack1 with rdata1=0x3C, rdata0 stays 0xA5, ack0 never pulses.
REQ-038 Reset in ISSUE of a write to addr 7 -> mem_write low after reset edge, no ack, busy=0, outputs zero, next tie granted to requester 0.
REQ-039 Protocol checks every cycle: never mem_write&&mem_read; gnt0&&gnt1 never; ack0&&ack1 never; exactly one ack per gnt absent reset.
REQ-040 Late drop: req1 pulsed for one cycle while a requester-0 transaction is in RESP -> no gnt1, no ack1.
